// File: rtl/fifo_v3.sv
// Single-clock circular FIFO with a programmable read count per pass, a registered
// read port and a replay mode that keeps read entries until a rewind or clear.
module fifo_v3 #(
    parameter int WIDTH            = 16,
    parameter int DEPTH            = 128,
    parameter int MAX_nDATA        = 1126,
    parameter int WIDTH_CONFIGBITS = $clog2(MAX_nDATA + 1),
    parameter int WIDTH_CNT        = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic                        re,
    input  logic                        clear,
    input  logic                        keep,
    input  logic                        rewind,
    input  logic [WIDTH-1:0]            data_in,
    input  logic [WIDTH_CONFIGBITS-1:0] config_bits,
    output logic                        full,
    output logic                        empty,
    output logic                        reachend,
    output logic [WIDTH_CNT-1:0]        count,
    output logic [WIDTH-1:0]            data_out,
    output logic                        valid_out
);

    localparam int                   PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]     PTR_MAX   = PTR_W'(DEPTH - 1);
    localparam logic [WIDTH_CNT-1:0] CNT_DEPTH = WIDTH_CNT'(DEPTH);

    // Increment with wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_MAX) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1'b1);
        end
        return r;
    endfunction

    logic [WIDTH-1:0]            mem_r [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_r, rd_ptr_r, base_ptr_r;
    logic [WIDTH_CNT-1:0]        used_r, count_r;
    logic [WIDTH_CONFIGBITS-1:0] rd_cnt_r, ndata_r;
    logic                        keep_r;
    logic [WIDTH-1:0]            data_out_r;
    logic                        valid_out_r;

    logic                        full_s, empty_s, reachend_s;
    logic                        wr_en_s, rd_en_s, rewind_s;
    logic [PTR_W-1:0]            wr_ptr_nxt_s, rd_ptr_nxt_s, base_ptr_nxt_s;
    logic [WIDTH_CNT-1:0]        used_nxt_s, count_nxt_s;
    logic [WIDTH_CONFIGBITS-1:0] rd_cnt_nxt_s;
    logic [WIDTH-1:0]            data_out_nxt_s;

    assign full_s     = (used_r == CNT_DEPTH);
    assign empty_s    = (count_r == {WIDTH_CNT{1'b0}});
    assign reachend_s = (rd_cnt_r == ndata_r);

    assign full      = full_s;
    assign empty     = empty_s;
    assign reachend  = reachend_s;
    assign count     = count_r;
    assign data_out  = data_out_r;
    assign valid_out = valid_out_r;

    // Handshake decode and next-state for pointers, counters and read data.
    always_comb begin
        wr_en_s        = we && !full_s;
        rewind_s       = rewind && keep_r;
        rd_en_s        = re && !empty_s && !reachend_s && !rewind_s;
        wr_ptr_nxt_s   = wr_ptr_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        rd_cnt_nxt_s   = rd_cnt_r;
        data_out_nxt_s = data_out_r;
        count_nxt_s    = count_r + WIDTH_CNT'(wr_en_s) - WIDTH_CNT'(rd_en_s);

        if (wr_en_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (rewind_s) begin
            rd_ptr_nxt_s = base_ptr_r;
            rd_cnt_nxt_s = {WIDTH_CONFIGBITS{1'b0}};
            count_nxt_s  = used_r + WIDTH_CNT'(wr_en_s);
        end else if (rd_en_s) begin
            rd_ptr_nxt_s   = ptr_inc(rd_ptr_r);
            rd_cnt_nxt_s   = rd_cnt_r + WIDTH_CONFIGBITS'(1'b1);
            data_out_nxt_s = mem_r[rd_ptr_r];
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // Replay mode pins base_ptr so read entries stay held; streaming frees on read.
        if (keep_r) begin
            base_ptr_nxt_s = base_ptr_r;
            used_nxt_s     = used_r + WIDTH_CNT'(wr_en_s);
        end else begin
            base_ptr_nxt_s = rd_ptr_nxt_s;
            used_nxt_s     = used_r + WIDTH_CNT'(wr_en_s) - WIDTH_CNT'(rd_en_s);
        end
    end

    // Storage array; writes are suppressed by reset and clear.
    always_ff @(posedge clk) begin
        if (rst && !clear && wr_en_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Control state register with synchronous reset and clear.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            base_ptr_r  <= {PTR_W{1'b0}};
            used_r      <= {WIDTH_CNT{1'b0}};
            count_r     <= {WIDTH_CNT{1'b0}};
            rd_cnt_r    <= {WIDTH_CONFIGBITS{1'b0}};
            ndata_r     <= config_bits;
            keep_r      <= keep;
            valid_out_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            base_ptr_r  <= base_ptr_nxt_s;
            used_r      <= used_nxt_s;
            count_r     <= count_nxt_s;
            rd_cnt_r    <= rd_cnt_nxt_s;
            ndata_r     <= ndata_r;
            keep_r      <= keep_r;
            valid_out_r <= rd_en_s;
        end
    end

    // Read data register: cleared only by reset, held through clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            data_out_r <= data_out_r;
        end else begin
            data_out_r <= data_out_nxt_s;
        end
    end

endmodule

// File: tb/tb_fifo_v3.sv
// Directed bench for fifo_v3 (DEPTH=4): queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_fifo_v3;
    localparam int W   = 16;
    localparam int D   = 4;
    localparam int CFW = 11;
    localparam int CNW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           we = 1'b0, re = 1'b0, clear = 1'b0, keep = 1'b0, rewind = 1'b0;
    logic [W-1:0]   data_in = 16'h0000;
    logic [CFW-1:0] config_bits = 11'd0;
    logic           full, empty, reachend, valid_out;
    logic [CNW-1:0] count;
    logic [W-1:0]   data_out;

    fifo_v3 #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .clear(clear), .keep(keep),
        .rewind(rewind), .data_in(data_in), .config_bits(config_bits),
        .full(full), .empty(empty), .reachend(reachend), .count(count),
        .data_out(data_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // reference model: held entries from base onward, read index, pass counter
    logic [W-1:0] mq[$];
    int           m_rd = 0;
    int           m_rdcnt = 0;
    int           m_nd = 0;
    bit           m_keep = 1'b0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_dout = 16'h0000;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_update();
        bit do_w, do_r, do_rw;
        if (!rst || clear) begin
            mq.delete();
            m_rd = 0; m_rdcnt = 0; m_valid = 1'b0;
            m_nd = int'(config_bits);
            m_keep = keep;
            if (!rst) m_dout = 16'h0000;
        end else begin
            do_w  = we && (mq.size() < D);
            do_rw = rewind && m_keep;
            do_r  = !do_rw && re && (mq.size() - m_rd > 0) && (m_rdcnt != m_nd);
            m_valid = do_r;
            if (do_r) begin
                m_dout = mq[m_rd];
                m_rdcnt++;
                if (m_keep) m_rd++;
                else void'(mq.pop_front());
            end
            if (do_rw) begin
                m_rd = 0;
                m_rdcnt = 0;
            end
            if (do_w) mq.push_back(data_in);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic ops(input bit w, input bit r, input logic [W-1:0] d);
        we = w; re = r; data_in = d; clear = 1'b0; rewind = 1'b0;
        tick();
    endtask

    task automatic do_clear(input logic [CFW-1:0] cfg, input bit k);
        we = 1'b0; re = 1'b0; rewind = 1'b0; clear = 1'b1; config_bits = cfg; keep = k;
        tick();
        clear = 1'b0; keep = 1'b0;
    endtask

    task automatic do_rewind(input bit w, input logic [W-1:0] d);
        we = w; re = 1'b0; data_in = d; clear = 1'b0; rewind = 1'b1;
        tick();
        rewind = 1'b0;
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("full", 32'(full), 32'(mq.size() == D));
            check("empty", 32'(empty), 32'((mq.size() - m_rd) == 0));
            check("reachend", 32'(reachend), 32'(m_rdcnt == m_nd));
            check("count", 32'(count), 32'(mq.size() - m_rd));
            check("valid_out", 32'(valid_out), 32'(m_valid));
            check("data_out", 32'(data_out), 32'(m_dout));
        end
    end

    initial begin
        int pulses;

        // reset with nData=5
        rst = 1'b0; config_bits = 11'd5;
        tick();
        rst = 1'b1; chk_en = 1'b1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_reachend", 32'(reachend), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        ops(1'b0, 1'b1, 16'h0000);
        check("rst_re_novalid", 32'(valid_out), 32'd0);
        ops(1'b0, 1'b1, 16'h0000);
        check("rst_re_novalid2", 32'(valid_out), 32'd0);

        // fill to full, drop the fifth write, drain in order
        do_clear(11'd20, 1'b0);
        for (int i = 0; i < 4; i++) ops(1'b1, 1'b0, 16'h00A0 + 16'(i));
        check("fill_full", 32'(full), 32'd1);
        ops(1'b1, 1'b0, 16'h00A4);
        check("fill_drop_count", 32'(count), 32'd4);
        check("model_used", 32'(mq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            ops(1'b0, 1'b1, 16'h0000);
            check("drain_data", 32'(data_out), 32'h00A0 + 32'(i));
            check("drain_valid", 32'(valid_out), 32'd1);
        end
        ops(1'b0, 1'b0, 16'h0000);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_valid_low", 32'(valid_out), 32'd0);

        // simultaneous read and write across pointer wrap
        do_clear(11'd20, 1'b0);
        ops(1'b1, 1'b0, 16'h00B0);
        for (int i = 0; i < 10; i++) begin
            ops(1'b1, 1'b1, 16'h00B1 + 16'(i));
            check("wrap_data", 32'(data_out), 32'h00B0 + 32'(i));
            check("wrap_valid", 32'(valid_out), 32'd1);
            check("wrap_count", 32'(count), 32'd1);
        end
        ops(1'b0, 1'b1, 16'h0000);
        check("wrap_last", 32'(data_out), 32'h00BA);
        check("wrap_empty", 32'(empty), 32'd1);

        // reachend with nData=3
        do_clear(11'd3, 1'b0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            ops(i < 6, 1'b1, 16'h00C0 + 16'(i));
            if (valid_out) pulses++;
            if (i == 2) check("reach_before", 32'(reachend), 32'd0);
            if (i == 3) begin
                check("reach_rise", 32'(reachend), 32'd1);
                check("reach_third", 32'(data_out), 32'h00C2);
            end
        end
        check("reach_pulses", 32'(pulses), 32'd3);
        check("reach_count", 32'(count), 32'd3);

        // replay: read entries stay held, rewind re-streams the tile
        do_clear(11'd4, 1'b1);
        for (int i = 0; i < 4; i++) ops(1'b1, 1'b0, 16'h0010 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            ops(1'b0, 1'b1, 16'h0000);
            check("replay_rd", 32'(data_out), 32'h0010 + 32'(i));
            check("replay_full", 32'(full), 32'd1);
        end
        check("replay_reach", 32'(reachend), 32'd1);
        check("replay_count0", 32'(count), 32'd0);
        do_rewind(1'b0, 16'h0000);
        check("rewind_reach", 32'(reachend), 32'd0);
        check("rewind_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            ops(1'b0, 1'b1, 16'h0000);
            check("reread", 32'(data_out), 32'h0010 + 32'(i));
        end
        // rewind ignored in streaming mode
        do_clear(11'd2, 1'b0);
        ops(1'b1, 1'b0, 16'h0020);
        ops(1'b1, 1'b1, 16'h0021);
        ops(1'b0, 1'b1, 16'h0000);
        check("stream_reach", 32'(reachend), 32'd1);
        do_rewind(1'b0, 16'h0000);
        check("stream_rewind_ign", 32'(reachend), 32'd1);
        ops(1'b0, 1'b1, 16'h0000);
        check("stream_refused", 32'(valid_out), 32'd0);

        // priority: clear beats we/re/rewind, reset zeroes data_out
        do_clear(11'd20, 1'b0);
        ops(1'b1, 1'b0, 16'h00D0);
        ops(1'b1, 1'b0, 16'h00D1);
        ops(1'b1, 1'b1, 16'h00D2);
        we = 1'b1; re = 1'b1; rewind = 1'b1; clear = 1'b1; data_in = 16'h00D3;
        tick();
        clear = 1'b0; rewind = 1'b0;
        check("prio_empty", 32'(empty), 32'd1);
        check("prio_count", 32'(count), 32'd0);
        check("prio_valid", 32'(valid_out), 32'd0);
        check("prio_dout_hold", 32'(data_out), 32'h00D0);
        ops(1'b1, 1'b0, 16'h00E0);
        ops(1'b1, 1'b1, 16'h00E1);
        check("pre_rst_dout", 32'(data_out), 32'h00E0);
        rst = 1'b0; we = 1'b1; re = 1'b1;
        tick();
        check("rst_mid_dout", 32'(data_out), 32'd0);
        check("rst_mid_empty", 32'(empty), 32'd1);
        rst = 1'b1;
        ops(1'b0, 1'b0, 16'h0000);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
